// File: rtl/data_mem_responder_pkg.sv
// Shared constants and state encoding for the data-memory responder.
package data_mem_responder_pkg;

  localparam int DMEM_WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with one-cycle registered read (read-before-write).
module dmem_ram #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 Clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem_r [DEPTH];

  // Array write and registered read port
  always_ff @(posedge Clock) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: latency model, request capture and RAM sequencing.
// Optional DMEM_RANGE_CHECK_EN adds the sticky AddrError out-of-range flag.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int WORD_SIZE = DMEM_WORD_SIZE,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataDone
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic                 AddrError
`endif
);

  localparam int ADDR_BITS = $clog2(DEPTH);

  logic                 req_s;
  logic                 oor_s;
  logic                 accept_s;
  logic                 ram_we_s;
  logic [ADDR_BITS-1:0] ram_addr_s;
  logic [WORD_SIZE-1:0] ram_wdata_s;
  logic [WORD_SIZE-1:0] ram_rdata_s;

  assign req_s = ReadData | WriteData;

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [WORD_SIZE:0] DEPTH_W = (WORD_SIZE + 1)'(DEPTH);
  logic addr_error_r;

  assign oor_s     = ({1'b0, DataAddr} >= DEPTH_W);
  assign AddrError = addr_error_r;

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_error_r <= 1'b0;
    end else if (accept_s && oor_s) begin
      addr_error_r <= 1'b1;
    end else begin
      addr_error_r <= addr_error_r;
    end
  end
`else
  assign oor_s = 1'b0;
`endif

  dmem_ram #(
    .WORD_SIZE(WORD_SIZE),
    .DEPTH    (DEPTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .Clock(Clock),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .wdata(ram_wdata_s),
    .rdata(ram_rdata_s)
  );

  generate
    if (LATENCY == 1) begin : g_lat1
      logic                 rd_pend_r;
      logic                 rd_oor_r;
      logic                 done_r;
      logic [WORD_SIZE-1:0] data_hold_r;
      logic [WORD_SIZE-1:0] data_in_s;

      assign accept_s    = req_s;
      assign ram_we_s    = WriteData & ~oor_s;
      assign ram_addr_s  = DataAddr[ADDR_BITS-1:0];
      assign ram_wdata_s = DataOut;

      // Fresh RAM word in the cycle after a read, otherwise the held value
      always_comb begin
        data_in_s = data_hold_r;
        if (rd_pend_r) begin
          data_in_s = rd_oor_r ? '0 : ram_rdata_s;
        end else begin
          data_in_s = data_hold_r;
        end
      end

      // Read-pending tracking and DataIn hold register
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          rd_pend_r   <= 1'b0;
          rd_oor_r    <= 1'b0;
          done_r      <= 1'b1;
          data_hold_r <= '0;
        end else begin
          rd_pend_r   <= ReadData & ~WriteData;
          rd_oor_r    <= oor_s;
          done_r      <= 1'b1;
          data_hold_r <= data_in_s;
        end
      end

      assign DataIn   = data_in_s;
      assign DataDone = done_r;
    end else begin : g_latn
      localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
      localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);
      localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

      dmem_state_t          state_r;
      logic [CNT_W-1:0]     cnt_r;
      logic [ADDR_BITS-1:0] addr_r;
      logic [WORD_SIZE-1:0] wdata_r;
      logic                 wr_r;
      logic                 oor_r;
      logic                 done_r;
      logic [WORD_SIZE-1:0] data_in_r;

      // RAM is read at acceptance and re-read from the captured address during WAIT
      assign accept_s    = (state_r == IDLE) && req_s;
      assign ram_addr_s  = (state_r == IDLE) ? DataAddr[ADDR_BITS-1:0] : addr_r;
      assign ram_wdata_s = wdata_r;
      assign ram_we_s    = (state_r == WAIT) && (cnt_r == '0) && wr_r && !oor_r;

      // Request FSM with latency counter and registered handshake outputs
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          addr_r    <= '0;
          wdata_r   <= '0;
          wr_r      <= 1'b0;
          oor_r     <= 1'b0;
          done_r    <= 1'b1;
          data_in_r <= '0;
        end else begin
          case (state_r)
            IDLE: begin
              if (req_s) begin
                state_r <= WAIT;
                cnt_r   <= CNT_LOAD;
                addr_r  <= DataAddr[ADDR_BITS-1:0];
                wdata_r <= DataOut;
                wr_r    <= WriteData;
                oor_r   <= oor_s;
                done_r  <= 1'b0;
              end
            end
            WAIT: begin
              if (cnt_r == '0) begin
                state_r <= DONE;
                done_r  <= 1'b1;
                if (!wr_r) begin
                  data_in_r <= oor_r ? '0 : ram_rdata_s;
                end
              end else begin
                cnt_r <= cnt_r - CNT_ONE;
              end
            end
            DONE: begin
              state_r <= IDLE;
            end
            default: begin
              state_r <= IDLE;
              done_r  <= 1'b1;
            end
          endcase
        end
      end

      assign DataIn   = data_in_r;
      assign DataDone = done_r;
    end
  endgenerate

endmodule
